uart_ascii_rx: RTL and testbench

Serial-to-character front end for the VGA ASCII terminal: receives 8N1 UART frames on a single input pin, filters and translates them to 7-bit ASCII, and drives the terminal's `add_char`/`char_value` write interface. It produces at most one single-cycle `add_char` strobe per received frame. It sits between the board's UART RX pin and the terminal, all in the terminal's `clk` domain.

---
 rtl/uart_ascii_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_ascii_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ascii_rx.sv
`default_nettype none
// =============================================================================
// Module   : uart_ascii_rx
// Brief    : UART 8N1 receiver with ASCII translation (CR->LF, CRLF->LF,
//            DEL->BS) driving the terminal add_char/char_value interface.
//            Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
// Revision : 1.0 - initial release
// =============================================================================
module uart_ascii_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_BITS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       add_char,
  output logic [6:0] char_value,
  output logic       frame_error
);

  localparam logic [CNT_BITS-1:0] c_half_m1 = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] c_bit_m1  = CNT_BITS'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;
`endif

  logic [1:0]          r_sync;
  state_t              r_state,   w_state_n;
  logic [CNT_BITS-1:0] r_cnt,     w_cnt_n;
  logic [2:0]          r_bit_idx, w_bit_idx_n;
  logic [7:0]          r_shift,   w_shift_n;
  logic                r_last_cr, w_last_cr_n;
  logic                r_add,     w_add_n;
  logic [6:0]          r_char,    w_char_n;
  logic                r_err,     w_err_n;
  logic                w_rx_s;
  logic                w_tick;
  logic                w_par_bad;

  // rx is asynchronous to clk; both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic r_par_err, w_par_err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_par_err <= 1'b0;
    else       r_par_err <= w_par_err_n;
  end

  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_last_cr <= 1'b0;
      r_add     <= 1'b0;
      r_char    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_last_cr <= w_last_cr_n;
      r_add     <= w_add_n;
      r_char    <= w_char_n;
      r_err     <= w_err_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_last_cr_n = r_last_cr;
    w_add_n     = 1'b0;
    w_char_n    = r_char;
    w_err_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_n = r_par_err;
`endif

    if (r_state != S_IDLE) begin
      w_cnt_n = w_tick ? c_bit_m1 : r_cnt - CNT_BITS'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_n = S_START;
          w_cnt_n   = c_half_m1;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_state_n = S_IDLE;
          end else begin
            w_bit_idx_n = '0;
            w_state_n   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_tick) begin
          w_shift_n   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_n = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_par_err_n = (^r_shift) ^ w_rx_s;
          w_state_n   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (w_tick) begin
          if (!w_rx_s) begin
            w_err_n   = 1'b1;
            w_state_n = S_RECOVER;
          end else begin
            w_state_n = S_IDLE;
            if (w_par_bad) begin
              w_err_n = 1'b1;
            end else if (!r_shift[7]) begin
              // Bytes with bit 7 set fall through untouched: dropped, last_cr kept
              if (r_shift == 8'h0D) begin
                w_add_n     = 1'b1;
                w_char_n    = 7'h0A;
                w_last_cr_n = 1'b1;
              end else if (r_shift == 8'h0A && r_last_cr) begin
                w_last_cr_n = 1'b0;
              end else begin
                w_add_n     = 1'b1;
                w_char_n    = (r_shift == 8'h7F) ? 7'h08 : r_shift[6:0];
                w_last_cr_n = 1'b0;
              end
            end
          end
        end
      end

      // A held-low line (break) must not be re-read as a string of zero frames
      S_RECOVER: begin
        if (w_rx_s) w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign add_char    = r_add;
  assign char_value  = r_char;
  assign frame_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_ascii_rx.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_ascii_rx
// Brief    : Self-checking bench for uart_ascii_rx: directed scenarios plus
//            random frames against a queue-based character model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_ascii_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // rx drive cycle -> strobe cycle: 2 sync flops, half bit, (9+PAR) bits, 1 register
  localparam int LAT = 2 + HALF + (9 + PAR) * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       add_char;
  logic [6:0] char_value;
  logic       frame_error;

  uart_ascii_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_BITS    (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .add_char   (add_char),
    .char_value (char_value),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         err;
    logic [6:0] val;
  } ev_t;

  ev_t        q[$];
  int         errors = 0;
  int         checks = 0;
  logic [6:0] m_char = 7'h00;
  bit         m_last_cr = 1'b0;
  bit         run_cmp = 1'b0;
  int         n_add = 0;
  int         n_err = 0;
  int         last_add_cyc = -1;
  logic [6:0] last_val = 7'h00;
  bit         exp_add, exp_err;
  ev_t        cur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Character-level model: what the terminal must see for one received frame
  task automatic model_frame(input logic [7:0] b, input bit ok, input int n0);
    ev_t e;
    e.cyc = n0 + LAT;
    e.err = 1'b0;
    e.val = 7'h00;
    if (!ok) begin
      e.err = 1'b1;
      q.push_back(e);
    end else if (b >= 8'h80) begin
      // dropped silently
    end else if (b == 8'h0D) begin
      e.val = 7'h0A;
      q.push_back(e);
      m_last_cr = 1'b1;
    end else if (b == 8'h0A && m_last_cr) begin
      m_last_cr = 1'b0;
    end else begin
      e.val = (b == 8'h7F) ? 7'h08 : b[6:0];
      q.push_back(e);
      m_last_cr = 1'b0;
    end
  endtask

  // Caller is at a negedge; returns at a negedge right after the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            output int n0);
    n0 = cyc;
    model_frame(b, stop_ok && (par_ok || PAR == 0), n0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ !par_ok;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model's event queue
  always @(negedge clk) begin
    if (reset) begin
      m_char = 7'h00;
    end else if (run_cmp) begin
      exp_add = 1'b0;
      exp_err = 1'b0;
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        cur = q.pop_front();
        if (cur.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL event_time: strobe due at cyc %0d not checked, now cyc %0d", cur.cyc, cyc);
        end else if (cur.err) begin
          exp_err = 1'b1;
        end else begin
          exp_add = 1'b1;
          m_char  = cur.val;
        end
      end
      checks++;
      if (add_char !== exp_add || frame_error !== exp_err || char_value !== m_char) begin
        errors++;
        $display("FAIL cycle_cmp at cyc %0d: got add=%b err=%b val=%h, expected add=%b err=%b val=%h",
                 cyc, add_char, frame_error, char_value, exp_add, exp_err, m_char);
      end
    end
  end

  always @(negedge clk) begin
    if (add_char) begin
      n_add++;
      last_add_cyc = cyc;
      last_val     = char_value;
    end
    if (frame_error) n_err++;
  end

  int         n0, a0, e0;
  logic [7:0] rb;
  bit         sok, pok;

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_add_char", add_char, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_char_value", char_value, 0);
    reset     = 1'b0;
    m_last_cr = 1'b0;
    run_cmp   = 1'b1;
    repeat (5) @(negedge clk);

    // Single 'A': exact latency and value
    a0 = n_add; e0 = n_err;
    send_frame(8'h41, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("A_latency", last_add_cyc - n0, 155 + 16 * PAR);
    chk("A_value", last_val, 7'h41);
    chk("A_count", n_add - a0, 1);
    chk("A_no_error", n_err - e0, 0);

    // CR LF LF back-to-back -> two newlines
    a0 = n_add; e0 = n_err;
    send_frame(8'h0D, 1'b1, 1'b1, n0);
    send_frame(8'h0A, 1'b1, 1'b1, n0);
    send_frame(8'h0A, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("crlf_count", n_add - a0, 2);
    chk("crlf_value", last_val, 7'h0A);
    chk("crlf_no_error", n_err - e0, 0);

    // DEL then high-bit byte
    a0 = n_add; e0 = n_err;
    send_frame(8'h7F, 1'b1, 1'b1, n0);
    send_frame(8'hC1, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("del_count", n_add - a0, 1);
    chk("del_value", last_val, 7'h08);
    chk("del_no_error", n_err - e0, 0);

    // Break for 40 bit times, then 'Z'
    a0 = n_add; e0 = n_err;
    n0 = cyc;
    q.push_back('{cyc: n0 + LAT, err: 1'b1, val: 7'h00});
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break_error_count", n_err - e0, 1);
    chk("break_no_add", n_add - a0, 0);
    send_frame(8'h5A, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("after_break_value", last_val, 7'h5A);
    chk("after_break_count", n_add - a0, 1);

    // 5-cycle glitch is rejected, then a normal frame still arrives
    a0 = n_add; e0 = n_err;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_add", n_add - a0, 0);
    chk("glitch_no_error", n_err - e0, 0);
    send_frame(8'h33, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("after_glitch_value", last_val, 7'h33);

    // Reset in the middle of data bit 3 aborts the frame
    a0 = n_add; e0 = n_err;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = k[0];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    reset     = 1'b1;
    m_last_cr = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_add", add_char, 0);
    chk("midreset_value", char_value, 0);
    chk("midreset_error", frame_error, 0);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("midreset_no_strobe", (n_add - a0) + (n_err - e0), 0);

`ifdef UART_RX_PARITY_EN
    a0 = n_add; e0 = n_err;
    send_frame(8'h41, 1'b1, 1'b0, n0);
    repeat (4) @(negedge clk);
    chk("parity_bad_error", n_err - e0, 1);
    chk("parity_bad_no_add", n_add - a0, 0);
    send_frame(8'h41, 1'b1, 1'b1, n0);
    repeat (4) @(negedge clk);
    chk("parity_good_add", n_add - a0, 1);
    chk("parity_good_value", last_val, 7'h41);
`endif

    // Random traffic biased towards the special characters
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = 8'h0D;
        1:       rb = 8'h0A;
        2:       rb = 8'h7F;
        3:       rb = 8'h80 | 8'($urandom_range(0, 127));
        default: rb = 8'($urandom_range(0, 255));
      endcase
      sok = ($urandom_range(0, 9) != 0);
      pok = ($urandom_range(0, 7) != 0);
      send_frame(rb, sok, pok, n0);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    repeat (3 * CPB) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
